mod_updown_counter: RTL and testbench
=====================================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised synchronous modulo-N up/down counter; next generation of the HC161 4-bit counter.
//  Adds width/modulus parameters, direction control, sync clear, clamped parallel load and overflow pulse.
//  Keeps HC161-style cep/cet enables and tc, so stages cascade (tc -> next cet, common cep).
//  Used standalone or chained for decade/BCD and wide counters.
// PARAMETERS
//  WIDTH    4          counter width in bits, >= 1
//  MODULUS  2**WIDTH   count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk  in   1      clock; all state changes on rising edge
//  mr   in   1      master reset, asynchronous, active-high
//  sr   in   1      synchronous clear, active-high
//  ld   in   1      synchronous parallel load, active-high
//  cep  in   1      count enable (parallel)
//  cet  in   1      count enable (trickle); also gates tc
//  up   in   1      direction: 1 = up, 0 = down
//  d    in   WIDTH  load data
//  q    out  WIDTH  count value (registered)
//  tc   out  1      terminal count (combinational)
//  ovf  out  1      wrap pulse (registered)
// BEHAVIOUR
//  - mr=1: q=0 and ovf=0 immediately, independent of clk; held while mr=1.
//  - Clock-edge priority: sr > ld > count > hold.
//  - sr=1: q<=0, ovf<=0.
//  - ld=1: q<=d if d<MODULUS, else q<=MODULUS-1 (clamp); ovf<=0; cep/cet/up ignored.
//  - count (cep&cet=1): up: q<=(q==MODULUS-1)?0:q+1; down: q<=(q==0)?MODULUS-1:q-1.
//  - hold (cep&cet=0): q unchanged, ovf<=0.
//  - tc = cet & (up ? q==MODULUS-1 : q==0); tc ignores cep, as on HC161.
//    After reset with up=1, tc=0; with up=0, tc=cet.
//  - ovf<=1 for exactly one cycle after a count edge where tc was 1; otherwise ovf<=0.
//  - up may change on any cycle; it takes effect on the next edge. tc follows up combinationally.
//  - Arithmetic is WIDTH bits wide. q never leaves 0..MODULUS-1 after reset.
//  - mr asserted mid-count: state is lost; counting resumes from 0 on the first edge after mr deasserts.
// CONFIGURATION
//  CNT_SAT_EN defined: saturating counter.
//    - Counting at terminal (up at MODULUS-1, or down at 0) holds q.
//    - ovf still pulses one cycle for each such attempted count.
//  CNT_SAT_EN undefined: wrap-around as in BEHAVIOUR.
// STRUCTURE
//  - counter_pkg holds DIR_UP=1'b1 and DIR_DOWN=1'b0.
//  - counter_pkg holds function clamp_load(d, MODULUS) and function next_count(q, up, MODULUS).
//  - No sub-module; the block is a single register stage plus next-state and terminal-detect logic.
// TESTING (WIDTH=4, MODULUS=10 unless noted)
//  1. q=7 mid-count, pulse mr=1 between edges -> q=0 and ovf=0 with no clock edge; tc=0 (up=1).
//  2. cep=cet=up=1 from q=0 for 10 edges -> q 0..9 then 0.
//     tc=1 only while q=9; ovf=1 for the single cycle after q 9->0.
//  3. Clamp and priority:
//     ld=1, d=4'hC -> q=9. ld=1, d=3 -> q=3. ld=1 and sr=1 on the same edge -> q=0.
//  4. Enable gating at q=9, up=1:
//     cet=0 -> tc=0, q holds. cep=0, cet=1 -> tc=1, q holds, ovf=0.
//  5. Down wrap at q=0, cep=cet=1, up=0:
//     default -> q=9, ovf pulses. CNT_SAT_EN -> q stays 0, ovf pulses each edge.
//  6. Cascade: two instances, stage0.tc -> stage1.cet, common cep=1, 100 edges.
//     {q1,q0} goes 00..99 -> 00; stage1.ovf pulses once.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared direction encodings and next-state helpers for mod_updown_counter.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic logic [31:0] clamp_load(
      input logic [31:0] d,
      input int unsigned modulus
   );
      return (d < modulus) ? d : 32'(modulus - 1);
   endfunction

   function automatic logic [31:0] next_count(
      input logic [31:0] q,
      input logic        up,
      input int unsigned modulus
   );
      logic [31:0] nxt;
      if (up == DIR_UP)
         nxt = (q == 32'(modulus - 1)) ? 32'd0 : q + 32'd1;
      else
         nxt = (q == 32'd0) ? 32'(modulus - 1) : q - 32'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Cascadable modulo-N up/down counter with HC161-style cep/cet/tc.
// Define CNT_SAT_EN for a saturating counter instead of wrap-around.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             mr,
   input  logic             sr,
   input  logic             ld,
   input  logic             cep,
   input  logic             cet,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

   logic             at_end;
   logic             cnt_en;
   logic [WIDTH-1:0] q_nxt;
   logic             ovf_nxt;

   assign at_end = (up == DIR_UP) ? (q == Q_MAX) : (q == '0);
   assign tc     = cet & at_end;
   assign cnt_en = cep & cet;

   always_comb begin
      q_nxt   = q;
      ovf_nxt = 1'b0;
      if (sr) begin
         q_nxt = '0;
      end else if (ld) begin
         q_nxt = WIDTH'(clamp_load(32'(d), MODULUS));
      end else if (cnt_en) begin
         // ovf flags every count attempted at the terminal value
         ovf_nxt = at_end;
`ifdef CNT_SAT_EN
         if (!at_end)
            q_nxt = WIDTH'(next_count(32'(q), up, MODULUS));
`else
         q_nxt = WIDTH'(next_count(32'(q), up, MODULUS));
`endif
      end
   end

   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         q   <= q_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10).
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic       mr = 1'b0, sr = 1'b0, ld = 1'b0;
   logic       cep = 1'b0, cet = 1'b0, up = 1'b1;
   logic [3:0] d = 4'd0;
   logic [3:0] q;
   logic       tc, ovf;

   logic       c_mr = 1'b0, c_cep = 1'b0, c_up = 1'b1;
   logic       c_zero = 1'b0, c_one = 1'b1;
   logic [3:0] c_d = 4'd0;
   logic [3:0] q0, q1;
   logic       tc0, tc1, ovf0, ovf1;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .mr(mr), .sr(sr), .ld(ld), .cep(cep), .cet(cet),
      .up(up), .d(d), .q(q), .tc(tc), .ovf(ovf)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (
      .clk(clk), .mr(c_mr), .sr(c_zero), .ld(c_zero), .cep(c_cep),
      .cet(c_one), .up(c_up), .d(c_d), .q(q0), .tc(tc0), .ovf(ovf0)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
      .clk(clk), .mr(c_mr), .sr(c_zero), .ld(c_zero), .cep(c_cep),
      .cet(tc0), .up(c_up), .d(c_d), .q(q1), .tc(tc1), .ovf(ovf1)
   );

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 mr = 1'b1;
      #1;
      ntot++;
      if (q !== 4'd0 || ovf !== 1'b0) $display("FAIL reset_q_ovf q=%0d ovf=%b want q=0 ovf=0", q, ovf);
      else npass++;
      @(negedge clk);
      mr = 1'b0;
      up = 1'b0; cet = 1'b1;
      #1;
      ntot++;
      if (tc !== 1'b1) $display("FAIL reset_tc_down tc=%b want 1", tc);
      else npass++;
      up = 1'b1;
      #1;
      ntot++;
      if (tc !== 1'b0) $display("FAIL reset_tc_up tc=%b want 0", tc);
      else npass++;
      // load 7, then async clear between edges
      @(negedge clk);
      ld = 1'b1; d = 4'd7;
      edge_wait();
      ld = 1'b0;
      ntot++;
      if (q !== 4'd7) $display("FAIL mid_load q=%0d want 7", q);
      else npass++;
      @(negedge clk);
      mr = 1'b1;
      #1;
      ntot++;
      if (q !== 4'd0 || ovf !== 1'b0 || tc !== 1'b0)
         $display("FAIL async_mr q=%0d ovf=%b tc=%b want 0/0/0", q, ovf, tc);
      else npass++;
      #2 mr = 1'b0;
   endtask

   task automatic test_count_up();
      @(negedge clk);
      cep = 1'b1; cet = 1'b1; up = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         ntot++;
         if (q !== 4'(i) || tc !== (i == 9))
            $display("FAIL up_step%0d q=%0d tc=%b want q=%0d tc=%b", i, q, tc, i, (i == 9));
         else npass++;
         edge_wait();
         ntot++;
         if (ovf !== (i == 9))
            $display("FAIL up_ovf%0d ovf=%b want %b", i, ovf, (i == 9));
         else npass++;
         @(negedge clk);
      end
      ntot++;
      if (q !== 4'd0) $display("FAIL up_wrap q=%0d want 0", q);
      else npass++;
      cep = 1'b0;
      edge_wait();
      ntot++;
      if (ovf !== 1'b0 || q !== 4'd0) $display("FAIL up_hold ovf=%b q=%0d want 0/0", ovf, q);
      else npass++;
   endtask

   task automatic test_load_clamp();
      @(negedge clk);
      ld = 1'b1; d = 4'hC;
      edge_wait();
      ntot++;
      if (q !== 4'd9 || ovf !== 1'b0) $display("FAIL clamp_c q=%0d ovf=%b want 9/0", q, ovf);
      else npass++;
      @(negedge clk);
      d = 4'd3; cep = 1'b1; up = 1'b0;
      edge_wait();
      ntot++;
      if (q !== 4'd3) $display("FAIL load_3 q=%0d want 3", q);
      else npass++;
      @(negedge clk);
      sr = 1'b1; d = 4'd5;
      edge_wait();
      ntot++;
      if (q !== 4'd0) $display("FAIL sr_over_ld q=%0d want 0", q);
      else npass++;
      @(negedge clk);
      sr = 1'b0; ld = 1'b0; cep = 1'b0; up = 1'b1;
   endtask

   task automatic test_enable_gating();
      @(negedge clk);
      ld = 1'b1; d = 4'd9;
      edge_wait();
      @(negedge clk);
      ld = 1'b0; up = 1'b1; cet = 1'b0; cep = 1'b1;
      #1;
      ntot++;
      if (tc !== 1'b0) $display("FAIL cet0_tc tc=%b want 0", tc);
      else npass++;
      edge_wait();
      ntot++;
      if (q !== 4'd9 || ovf !== 1'b0) $display("FAIL cet0_hold q=%0d ovf=%b want 9/0", q, ovf);
      else npass++;
      @(negedge clk);
      cep = 1'b0; cet = 1'b1;
      #1;
      ntot++;
      if (tc !== 1'b1) $display("FAIL cep0_tc tc=%b want 1", tc);
      else npass++;
      edge_wait();
      ntot++;
      if (q !== 4'd9 || ovf !== 1'b0) $display("FAIL cep0_hold q=%0d ovf=%b want 9/0", q, ovf);
      else npass++;
   endtask

   task automatic test_down_wrap();
      @(negedge clk);
      sr = 1'b1;
      edge_wait();
      @(negedge clk);
      sr = 1'b0; up = 1'b0; cep = 1'b1; cet = 1'b1;
      #1;
      ntot++;
      if (tc !== 1'b1) $display("FAIL down_tc tc=%b want 1", tc);
      else npass++;
      edge_wait();
`ifdef CNT_SAT_EN
      ntot++;
      if (q !== 4'd0 || ovf !== 1'b1) $display("FAIL sat_1 q=%0d ovf=%b want 0/1", q, ovf);
      else npass++;
      edge_wait();
      ntot++;
      if (q !== 4'd0 || ovf !== 1'b1) $display("FAIL sat_2 q=%0d ovf=%b want 0/1", q, ovf);
      else npass++;
`else
      ntot++;
      if (q !== 4'd9 || ovf !== 1'b1) $display("FAIL down_wrap q=%0d ovf=%b want 9/1", q, ovf);
      else npass++;
      edge_wait();
      ntot++;
      if (q !== 4'd8 || ovf !== 1'b0) $display("FAIL down_step q=%0d ovf=%b want 8/0", q, ovf);
      else npass++;
`endif
      @(negedge clk);
      cep = 1'b0; up = 1'b1;
   endtask

   task automatic test_cascade();
      int pulses = 0;
      int bad = 0;
      @(negedge clk);
      c_mr = 1'b1;
      #1 c_mr = 1'b0;
      c_cep = 1'b1; c_up = 1'b1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (q1 !== 4'(i / 10) || q0 !== 4'(i % 10)) begin
            bad++;
            $display("FAIL cascade_val%0d got %0d%0d want %0d", i, q1, q0, i);
         end
         edge_wait();
         if (ovf1 === 1'b1) pulses++;
         @(negedge clk);
      end
      ntot++;
      if (bad != 0) $display("FAIL cascade_seq bad_steps=%0d want 0", bad);
      else npass++;
      ntot++;
      if (q1 !== 4'd0 || q0 !== 4'd0) $display("FAIL cascade_wrap got %0d%0d want 00", q1, q0);
      else npass++;
      ntot++;
      if (pulses != 1) $display("FAIL cascade_ovf1 pulses=%0d want 1", pulses);
      else npass++;
      c_cep = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_load_clamp();
      test_enable_gating();
      test_down_wrap();
      test_cascade();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
